// File: rtl/cla_nibble_seq_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// cla_nibble_seq_ctrl_pkg
//   Shared definitions for the nibble-serial CLA adder sequencer:
//   nibble width, FSM state encoding and the two's-complement overflow rule.
// -----------------------------------------------------------------------------
package cla_nibble_seq_ctrl_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Signed overflow: both operands share a sign and the result sign differs.
    function automatic logic add_overflow(input logic a_msb,
                                          input logic b_msb,
                                          input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/cla_nibble_seq_ctrl_cla4.sv
// -----------------------------------------------------------------------------
// CarryLA_4
//   Existing purely combinational 4-bit carry-lookahead adder.
//   Ports:
//     a, b  in  4  operand nibbles
//     cin   in  1  carry in
//     sum   out 4  a + b + cin (low 4 bits)
//     cout  out 1  carry out of bit 3
// -----------------------------------------------------------------------------
module CarryLA_4
    import cla_nibble_seq_ctrl_pkg::*;
(
    input  logic [NIB_W-1:0] a,
    input  logic [NIB_W-1:0] b,
    input  logic             cin,
    output logic [NIB_W-1:0] sum,
    output logic             cout
);

    logic [NIB_W-1:0] g;
    logic [NIB_W-1:0] p;
    logic [NIB_W:0]   c;

    assign g = a & b;
    assign p = a ^ b;

    // Every carry is a flat sum of products of g/p and cin, so no carry
    // ripples through another carry.
    always_comb begin
        c[0] = cin;
        c[1] = g[0] | (p[0] & cin);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & cin);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & cin);
    end

    assign sum  = p ^ c[NIB_W-1:0];
    assign cout = c[NIB_W];

endmodule

// File: rtl/cla_nibble_seq_ctrl.sv
// -----------------------------------------------------------------------------
// cla_nibble_seq_ctrl
//   Time-multiplexes one CarryLA_4 to perform a W = 4*NIBBLES bit add, one
//   nibble per clock, LSB first, with a start/busy/done handshake.
//   Ports:
//     clk       in   1  rising-edge clock
//     rst       in   1  synchronous reset, active-high
//     start     in   1  request an add (accepted in IDLE or DONE only)
//     op_a      in   W  operand A, captured when start is accepted
//     op_b      in   W  operand B, captured when start is accepted
//     cin       in   1  carry into nibble 0, captured with the operands
//     busy      out  1  high while the add is in progress
//     done      out  1  one-cycle pulse; result valid from this cycle
//     sum       out  W  registered sum, held until the next completion
//     cout      out  1  carry out of the MSB nibble
//     overflow  out  1  two's-complement overflow of the W-bit add
// -----------------------------------------------------------------------------
module cla_nibble_seq_ctrl
    import cla_nibble_seq_ctrl_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NIB_W*NIBBLES-1:0] op_a,
    input  logic [NIB_W*NIBBLES-1:0] op_b,
    input  logic                     cin,
    output logic                     busy,
    output logic                     done,
    output logic [NIB_W*NIBBLES-1:0] sum,
    output logic                     cout,
    output logic                     overflow
);

    localparam int W     = NIB_W * NIBBLES;
    localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [W-1:0]     a_sr_q;
    logic [W-1:0]     b_sr_q;
    logic             carry_q;
    logic [W-1:0]     partial_q;
    logic [W-1:0]     partial_d;
    logic [W-1:0]     sum_q;
    logic             cout_q;
    logic             ovf_q;

    logic [NIB_W-1:0] cla_sum;
    logic             cla_cout;
    logic             accept;
    logic             last_nib;

    CarryLA_4 u_cla (
        .a    (a_sr_q[NIB_W-1:0]),
        .b    (b_sr_q[NIB_W-1:0]),
        .cin  (carry_q),
        .sum  (cla_sum),
        .cout (cla_cout)
    );

    // start has no effect while RUN; the current operation is never disturbed.
    assign accept   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign last_nib = (state_q == ST_RUN) && (cnt_q == LAST);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        // NOTE: sequential state is written with <= so every flop samples the
        // pre-edge values of the others, independent of block ordering.
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        // NOTE: assigning the default first means every path writes state_d,
        // so no latch is inferred for the unlisted cases.
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (start) state_d = ST_RUN;
            ST_RUN:  if (cnt_q == LAST) state_d = ST_DONE;
            ST_DONE: state_d = start ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Partial sum with the nibble currently leaving the CLA merged in; on the
    // final edge this is the complete result.
    always_comb begin
        partial_d = partial_q;
        partial_d[NIB_W*int'(cnt_q) +: NIB_W] = cla_sum;
    end

    // ---------------- datapath ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the shift and partial registers are cleared as well, even
            // though each op overwrites them, so nothing downstream ever sees X.
            cnt_q     <= '0;
            a_sr_q    <= '0;
            b_sr_q    <= '0;
            carry_q   <= 1'b0;
            partial_q <= '0;
            sum_q     <= '0;
            cout_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else if (accept) begin
            a_sr_q  <= op_a;
            b_sr_q  <= op_b;
            carry_q <= cin;
            cnt_q   <= '0;
        end else if (state_q == ST_RUN) begin
            partial_q <= partial_d;
            carry_q   <= cla_cout;
            a_sr_q    <= a_sr_q >> NIB_W;
            b_sr_q    <= b_sr_q >> NIB_W;
            if (last_nib) begin
                // Counter parks at LAST instead of wrapping.
                sum_q  <= partial_d;
                cout_q <= cla_cout;
                ovf_q  <= add_overflow(a_sr_q[NIB_W-1], b_sr_q[NIB_W-1],
                                       cla_sum[NIB_W-1]);
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign busy     = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);
    assign sum      = sum_q;
    assign cout     = cout_q;
    assign overflow = ovf_q;

endmodule
